// File: rtl/bypass_scoreboard.sv
// rtl/bypass_scoreboard.sv - register-bypass scoreboard with load-use stall detection
//
// Tracks the destination of every instruction in the post-issue stages (0 = EX,
// DEPTH-1 = WB). It picks a forwarding source for each decode read port and
// raises stall when a load's data is not yet available.
//
// Ports:
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   issue_*          decode-stage instruction: valid, regwr, isload, wsel, rsel, ruse
//   advance          pipeline enable; when low all state holds
//   flush            squash the decode instruction (bubble into stage 0, no stall)
//   stall            hold fetch/decode, bubble into stage 0
//   fwd_sel          per-port operand source: 0 = regfile, k+1 = stage k output
//   inflight         count of valid register-writing entries
//   stall_cnt        saturating count of advancing stall cycles
module bypass_scoreboard #(
    parameter int RB         = 5,
    parameter int DEPTH      = 3,
    parameter int NPORTS     = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   issue_valid,
    input  logic                   issue_regwr,
    input  logic                   issue_isload,
    input  logic [RB-1:0]          issue_wsel,
    input  logic [NPORTS*RB-1:0]   issue_rsel,
    input  logic [NPORTS-1:0]      issue_ruse,
    input  logic                   advance,
    input  logic                   flush,
    output logic                   stall,
    output logic [NPORTS*SW-1:0]   fwd_sel,
    output logic [SW-1:0]          inflight,
    output logic [15:0]            stall_cnt
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [DEPTH-1:0] regwr_q, regwr_d;
    logic [DEPTH-1:0] isload_q, isload_d;
    logic [RB-1:0]    wsel_q [DEPTH];
    logic [RB-1:0]    wsel_d [DEPTH];
    logic [15:0]      stall_cnt_q, stall_cnt_d;

    logic [SW-1:0]     port_sel [NPORTS];
    logic [NPORTS-1:0] port_late;
    logic              hazard;
    logic              take_issue;

    // Forward select: scan oldest to youngest so the youngest match overwrites.
    always_comb begin
        hazard = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            port_sel[p]  = '0;
            port_late[p] = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (issue_ruse[p] && v_q[k] && regwr_q[k] &&
                    (wsel_q[k] == issue_rsel[p*RB +: RB]) &&
                    (issue_rsel[p*RB +: RB] != '0)) begin
                    port_sel[p]  = SW'(k + 1);
                    // Load result only exists from LOAD_STAGE onward.
                    port_late[p] = isload_q[k] && (k < LOAD_STAGE);
                end
            end
            fwd_sel[p*SW +: SW] = port_sel[p];
            hazard = hazard | port_late[p];
        end
    end

    // Flush wins over a hazard: the squashed instruction never needs its operand.
    assign stall      = issue_valid && !flush && hazard;
    assign take_issue = !stall && !flush;

    always_comb begin
        v_d         = v_q;
        regwr_d     = regwr_q;
        isload_d    = isload_q;
        wsel_d      = wsel_q;
        stall_cnt_d = stall_cnt_q;
        if (advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                v_d[k]      = v_q[k-1];
                regwr_d[k]  = regwr_q[k-1];
                isload_d[k] = isload_q[k-1];
                wsel_d[k]   = wsel_q[k-1];
            end
            if (take_issue) begin
                v_d[0]      = issue_valid;
                regwr_d[0]  = issue_regwr;
                isload_d[0] = issue_isload;
                wsel_d[0]   = issue_wsel;
            end else begin
                v_d[0]      = 1'b0;
                regwr_d[0]  = 1'b0;
                isload_d[0] = 1'b0;
                wsel_d[0]   = '0;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v_q         <= '0;
            regwr_q     <= '0;
            isload_q    <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                wsel_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            regwr_q     <= regwr_d;
            isload_q    <= isload_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                wsel_q[k] <= wsel_d[k];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight = inflight + SW'(v_q[k] & regwr_q[k]);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb/tb_bypass_scoreboard.sv - scoreboard bench for bypass_scoreboard
module tb_bypass_scoreboard;

    logic        CLK;
    logic        nRST;
    logic        issue_valid;
    logic        issue_regwr;
    logic        issue_isload;
    logic [4:0]  issue_wsel;
    logic [9:0]  issue_rsel;
    logic [1:0]  issue_ruse;
    logic        advance;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [1:0]  inflight;
    logic [15:0] stall_cnt;

    bypass_scoreboard dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .issue_valid  (issue_valid),
        .issue_regwr  (issue_regwr),
        .issue_isload (issue_isload),
        .issue_wsel   (issue_wsel),
        .issue_rsel   (issue_rsel),
        .issue_ruse   (issue_ruse),
        .advance      (advance),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .inflight     (inflight),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        string       tag;
        logic        stall;
        logic [3:0]  fs;
        logic [1:0]  infl;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_vec(input string tag,
                             input logic v, input logic rw, input logic ld, input logic [4:0] ws,
                             input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] ruse,
                             input logic adv, input logic fl,
                             input logic e_st, input logic [3:0] e_fs,
                             input logic [1:0] e_in, input logic [15:0] e_cnt);
        exp_t e;
        issue_valid  = v;
        issue_regwr  = rw;
        issue_isload = ld;
        issue_wsel   = ws;
        issue_rsel   = {rs1, rs0};
        issue_ruse   = ruse;
        advance      = adv;
        flush        = fl;
        e.tag   = tag;
        e.stall = e_st;
        e.fs    = e_fs;
        e.infl  = e_in;
        e.cnt   = e_cnt;
        exp_q.push_back(e);
    endtask

    task automatic compare_vec();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val({e.tag, ".stall"},    {31'd0, stall},    {31'd0, e.stall});
            check_val({e.tag, ".fwd_sel"},  {28'd0, fwd_sel},  {28'd0, e.fs});
            check_val({e.tag, ".inflight"}, {30'd0, inflight}, {30'd0, e.infl});
            check_val({e.tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, e.cnt});
        end
    endtask

    task automatic step(input string tag,
                        input logic v, input logic rw, input logic ld, input logic [4:0] ws,
                        input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] ruse,
                        input logic adv, input logic fl,
                        input logic e_st, input logic [3:0] e_fs,
                        input logic [1:0] e_in, input logic [15:0] e_cnt);
        apply_vec(tag, v, rw, ld, ws, rs0, rs1, ruse, adv, fl, e_st, e_fs, e_in, e_cnt);
        @(negedge CLK);
        compare_vec();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b1;
        apply_vec("init", 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 4'h0, 2'd0, 16'h0);
        void'(exp_q.pop_front());
        #2 nRST = 1'b0;
        #1;
        check_val("rst.stall",     {31'd0, stall},    32'd0);
        check_val("rst.fwd_sel",   {28'd0, fwd_sel},  32'd0);
        check_val("rst.inflight",  {30'd0, inflight}, 32'd0);
        check_val("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        #9 nRST = 1'b1;
        @(posedge CLK);
        #1;

        // ALU forwarding: stage 0 then stage 1
        step("add3",     1, 1, 0, 5'd3,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd0, 16'h0);
        step("rd3_s0",   1, 1, 0, 5'd4,  5'd3,  5'd0,  2'b01, 1, 0, 0, 4'h1, 2'd1, 16'h0);
        step("rd3_s1",   1, 0, 0, 5'd0,  5'd3,  5'd0,  2'b01, 1, 0, 0, 4'h2, 2'd2, 16'h0);
        step("drain0",   0, 0, 0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd2, 16'h0);
        step("drain1",   0, 0, 0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd1, 16'h0);
        step("drain2",   0, 0, 0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd0, 16'h0);
        // Load-use: one stall cycle, then forward from stage 1 on port 1
        step("lw5",      1, 1, 1, 5'd5,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd0, 16'h0);
        step("lu_stall", 1, 1, 0, 5'd6,  5'd0,  5'd5,  2'b10, 1, 0, 1, 4'h4, 2'd1, 16'h0);
        step("lu_fwd",   1, 1, 0, 5'd6,  5'd0,  5'd5,  2'b10, 1, 0, 0, 4'h8, 2'd1, 16'h1);
        // Youngest wins; $0 never matches
        step("w7a",      1, 1, 0, 5'd7,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd2, 16'h1);
        step("w0",       1, 1, 0, 5'd0,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd2, 16'h1);
        step("w7b",      1, 1, 0, 5'd7,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd3, 16'h1);
        step("rd7_rd0",  1, 0, 0, 5'd0,  5'd7,  5'd0,  2'b11, 1, 0, 0, 4'h1, 2'd3, 16'h1);
        // Flush beats hazard
        step("lw9",      1, 1, 1, 5'd9,  5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd2, 16'h1);
        step("flush_lu", 1, 1, 0, 5'd10, 5'd9,  5'd0,  2'b01, 1, 1, 0, 4'h1, 2'd2, 16'h1);
        step("lw11",     1, 1, 1, 5'd11, 5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd1, 16'h1);
        // Frozen pipeline during hazard
        for (int i = 0; i < 5; i++) begin
            step("hold",  1, 1, 0, 5'd12, 5'd11, 5'd0, 2'b01, 0, 0, 1, 4'h1, 2'd2, 16'h1);
        end
        step("hold_go",  1, 1, 0, 5'd12, 5'd11, 5'd0,  2'b01, 1, 0, 1, 4'h1, 2'd2, 16'h1);
        check_val("cnt_after_go", {16'd0, stall_cnt}, 32'd2);

        // Saturation: preload the counter near its top
        force dut.stall_cnt_q = 16'hFFFE;
        #1 release dut.stall_cnt_q;
        step("lw12",     1, 1, 1, 5'd12, 5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd1, 16'hFFFE);
        step("sat_a",    1, 1, 0, 5'd20, 5'd12, 5'd0,  2'b01, 1, 0, 1, 4'h1, 2'd2, 16'hFFFE);
        step("lw13",     1, 1, 1, 5'd13, 5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd1, 16'hFFFF);
        step("sat_b",    1, 1, 0, 5'd21, 5'd0,  5'd13, 2'b10, 1, 0, 1, 4'h4, 2'd2, 16'hFFFF);
        step("w15",      1, 1, 0, 5'd15, 5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd1, 16'hFFFF);
        step("w16",      1, 1, 0, 5'd16, 5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd2, 16'hFFFF);
        step("lw14",     1, 1, 1, 5'd14, 5'd0,  5'd0,  2'b00, 1, 0, 0, 4'h0, 2'd2, 16'hFFFF);

        // Asynchronous reset in the middle of a stall
        apply_vec("pre_rst", 1, 1, 0, 5'd22, 5'd14, 5'd0, 2'b01, 1, 0, 1, 4'h1, 2'd3, 16'hFFFF);
        @(negedge CLK);
        compare_vec();
        #2 nRST = 1'b0;
        #1;
        check_val("arst.stall",     {31'd0, stall},    32'd0);
        check_val("arst.fwd_sel",   {28'd0, fwd_sel},  32'd0);
        check_val("arst.inflight",  {30'd0, inflight}, 32'd0);
        check_val("arst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        step("post_rst", 1, 1, 0, 5'd22, 5'd14, 5'd0,  2'b01, 1, 0, 0, 4'h0, 2'd0, 16'h0);
        step("post_rst2", 0, 0, 0, 5'd0, 5'd22, 5'd0,  2'b01, 1, 0, 0, 4'h1, 2'd1, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bypass_scoreboard.md
BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 The module SHALL have parameter RB, default 5, meaning register-select width (2^RB architectural registers, register 0 hard-wired zero).
REQ-002 The module SHALL have parameter DEPTH, default 3, meaning number of post-issue stages tracked (stage 0 = EX, stage DEPTH-1 = WB).
REQ-003 The module SHALL have parameter NPORTS, default 2, meaning number of source-operand read ports.
REQ-004 The module SHALL have parameter LOAD_STAGE, default 1, meaning the lowest stage index whose output carries valid load data (range 0..DEPTH-1).
REQ-005 The module SHALL have parameter SW, derived as clog2(DEPTH+1), meaning forward-select width.
REQ-006 The module SHALL have port CLK, input, 1 bit: system clock, all state on rising edge.
REQ-007 The module SHALL have port nRST, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The module SHALL have port issue_valid, input, 1 bit: the instruction in decode is real (not a bubble).
REQ-009 The module SHALL have port issue_regwr, input, 1 bit: the decode instruction writes a register.
REQ-010 The module SHALL have port issue_isload, input, 1 bit: the decode instruction is a load.
REQ-011 The module SHALL have port issue_wsel, input, RB bits: destination register of the decode instruction.
REQ-012 The module SHALL have port issue_rsel, input, NPORTS*RB bits: source registers; port p occupies bits [p*RB +: RB].
REQ-013 The module SHALL have port issue_ruse, input, NPORTS bits: port p actually reads its source.
REQ-014 The module SHALL have port advance, input, 1 bit: pipeline enable (all caches hit this cycle).
REQ-015 The module SHALL have port flush, input, 1 bit: squash the decode instruction (taken branch/jump).
REQ-016 The module SHALL have port stall, output, 1 bit: hold fetch/decode and insert a bubble into stage 0.
REQ-017 The module SHALL have port fwd_sel, output, NPORTS*SW bits: per-port operand source; 0 = register file, k+1 = output of stage k.
REQ-018 The module SHALL have port inflight, output, SW bits: count of valid, register-writing entries in stages 0..DEPTH-1.
REQ-019 The module SHALL have port stall_cnt, output, 16 bits: saturating count of cycles with stall=1 and advance=1.

Function
REQ-020 The module SHALL hold per-stage entry k = {v, regwr, isload, wsel}.
REQ-021 A port p SHALL match stage k when issue_ruse[p], entry k v and regwr, wsel==rsel_p, and rsel_p != 0.
REQ-022 fwd_sel for port p SHALL equal k+1 for the lowest matching k (youngest wins), or 0 if no match; combinational, independent of advance.
REQ-023 A load-use hazard SHALL exist when, for any port, the selected stage k has isload=1 and k < LOAD_STAGE.
REQ-024 stall SHALL be asserted exactly when issue_valid=1, flush=0, and a load-use hazard exists; combinational.
REQ-025 With advance=0, all entries and stall_cnt SHALL hold; outputs still track the inputs combinationally.
REQ-026 With advance=1, entry k SHALL be loaded from entry k-1 for k=1..DEPTH-1, and the oldest entry SHALL be discarded.
REQ-027 With advance=1, entry 0 SHALL load {issue_valid, issue_regwr, issue_isload, issue_wsel} when stall=0 and flush=0, otherwise a bubble (v=0).
REQ-028 flush and a hazard together SHALL yield flush priority: stall=0, bubble into stage 0, older stages shift normally.
REQ-029 A write to register 0 SHALL be tracked but never match; its fwd_sel SHALL stay 0.
REQ-030 stall_cnt SHALL increment by 1 on each edge with stall=1 and advance=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-031 inflight SHALL reflect the registered entries only, combinationally.
REQ-032 Stall-to-issue latency SHALL be: a load in stage 0 with LOAD_STAGE=1 stalls a dependent exactly 1 advancing cycle, then fwd_sel = 2.

Reset
REQ-033 nRST low SHALL immediately clear all entry v, regwr, isload bits, all wsel fields to 0, and stall_cnt to 0, independent of CLK.
REQ-034 During and after reset, stall=0, fwd_sel=0, and inflight=0 until the first advancing edge with a valid issue.
REQ-035 Reset asserted mid-stall SHALL discard all in-flight entries; the first post-reset cycle SHALL not stall.

Verification
REQ-036 Issue add $3 (regwr), advance; next issue reads $3 on port 0 -> fwd_sel[0]=1, stall=0; one more advance -> fwd_sel[0]=2.
REQ-037 Issue lw $5, advance; next reads $5 on port 1 -> stall=1, stall_cnt 0->1; advance -> stall=0, fwd_sel[1]=2.
REQ-038 Stages 0 and 2 both write $7, port 0 reads $7 -> fwd_sel[0]=1 (youngest); write to $0 read on $0 -> fwd_sel=0.
REQ-039 Load-use hazard with flush=1 -> stall=0, stage 0 becomes bubble, inflight unchanged by the squashed issue.
REQ-040 Hold advance=0 for 5 cycles during a hazard -> entries, stall=1, and stall_cnt all frozen; force stall_cnt to FFFF -> stays FFFF.
REQ-041 Assert nRST low asynchronously with 3 valid entries and stall=1 -> inflight=0, stall=0, stall_cnt=0 before the next CLK edge.
